// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code checker: FSM states, Gray word width
// and the Gray-to-binary conversion used by the decoder.
package gray_pkg;

  localparam int GRAY_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic logic [GRAY_W-1:0] gray_to_bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary decoder.
module gray2bin
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] Gray,
  output logic [GRAY_W-1:0] Bin
);

  assign Bin = gray_to_bin(Gray);

endmodule

// File: rtl/gray_checker.sv
// Monitors a 3-bit Gray counter stream: decodes each sample, checks that
// consecutive samples advance by at most one, counts 7->0 wraps and checks
// the upstream Overflow flag for consistency with those wraps.
module gray_checker #(
  parameter int WRAP_W = 8,
  parameter int GRAY_W = gray_pkg::GRAY_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [GRAY_W-1:0] Gray,
  input  logic              Ovf_in,
  input  logic              Clr,
  output logic [GRAY_W-1:0] Bin,
  output logic              Bin_valid,
  output logic              Step_err,
  output logic              Ovf_err,
  output logic              Err_sticky,
  output logic [WRAP_W-1:0] Wrap_cnt
);

  import gray_pkg::*;

  state_t            state_reg;
  logic [GRAY_W-1:0] prev_reg;
  logic [GRAY_W-1:0] bin_reg;
  logic              bin_valid_reg;
  logic              step_err_reg;
  logic              ovf_err_reg;
  logic              ovf_seen_reg;
  logic              err_sticky_reg;
  logic [WRAP_W-1:0] wrap_cnt_reg;

  logic [GRAY_W-1:0] dec;
  logic [GRAY_W-1:0] step_d;
  logic              step_ok;
  logic              step_bad;
  logic              wrap_hit;
  logic              ovf_bad;

  gray2bin u_gray2bin (
    .Gray (Gray),
    .Bin  (dec)
  );

  // Classify the current sample against the previous one and judge Ovf_in.
  always_comb begin
    step_d   = dec - prev_reg;
    step_ok  = (step_d == GRAY_W'(1));
    step_bad = (state_reg == TRACK) && (step_d != '0) && !step_ok;
    wrap_hit = (state_reg == TRACK) && step_ok && (prev_reg == '1);
    ovf_bad  = (wrap_hit && !Ovf_in)
            || (Ovf_in && (wrap_cnt_reg == '0) && !wrap_hit)
            || (!Ovf_in && ovf_seen_reg);
  end

  // Tracking FSM with registered outputs; Reset beats Clr, Clr beats Valid.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg      <= IDLE;
      prev_reg       <= '0;
      bin_reg        <= '0;
      bin_valid_reg  <= 1'b0;
      step_err_reg   <= 1'b0;
      ovf_err_reg    <= 1'b0;
      ovf_seen_reg   <= 1'b0;
      err_sticky_reg <= 1'b0;
      wrap_cnt_reg   <= '0;
    end else if (Clr) begin
      // Bin deliberately holds across a soft clear.
      state_reg      <= IDLE;
      prev_reg       <= '0;
      bin_valid_reg  <= 1'b0;
      step_err_reg   <= 1'b0;
      ovf_err_reg    <= 1'b0;
      ovf_seen_reg   <= 1'b0;
      err_sticky_reg <= 1'b0;
      wrap_cnt_reg   <= '0;
    end else begin
      bin_valid_reg <= Valid;
      step_err_reg  <= 1'b0;
      if (Valid) begin
        bin_reg <= dec;
        case (state_reg)
          IDLE, TRACK: begin
            prev_reg     <= dec;
            ovf_seen_reg <= ovf_seen_reg | Ovf_in;
            if (ovf_bad) begin
              ovf_err_reg <= 1'b1;
            end
            if (wrap_hit && (wrap_cnt_reg != '1)) begin
              wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
            end
            if (step_bad) begin
              step_err_reg   <= 1'b1;
              err_sticky_reg <= 1'b1;
              state_reg      <= FAULT;
            end else begin
              state_reg <= TRACK;
            end
          end
          default: begin
            // FAULT: decode only; counters and checks stay frozen.
          end
        endcase
      end
    end
  end

  assign Bin        = bin_reg;
  assign Bin_valid  = bin_valid_reg;
  assign Step_err   = step_err_reg;
  assign Ovf_err    = ovf_err_reg;
  assign Err_sticky = err_sticky_reg;
  assign Wrap_cnt   = wrap_cnt_reg;

endmodule

// File: doc/gray_checker.md
GRAY_CHECKER -- requirements
Module: gray_checker

Interface
REQ-001 SHALL have parameter WRAP_W, default 8, width of the wrap counter.
REQ-002 SHALL have parameter GRAY_W, default 3, width of the Gray input; fixed at 3 for this revision.
REQ-003 SHALL have port Clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous, active-low reset; sampled only on a rising Clk edge.
REQ-005 SHALL have port Valid, input, 1, marks Gray/Ovf_in as a sample this cycle.
REQ-006 SHALL have port Gray, input, 3, Gray code word from the upstream gray counter.
REQ-007 SHALL have port Ovf_in, input, 1, upstream Overflow flag.
REQ-008 SHALL have port Clr, input, 1, synchronous soft clear, active-high.
REQ-009 SHALL have port Bin, output, 3, registered binary decode of the last valid sample.
REQ-010 SHALL have port Bin_valid, output, 1, one-cycle pulse qualifying Bin.
REQ-011 SHALL have port Step_err, output, 1, one-cycle pulse on an illegal step.
REQ-012 SHALL have port Ovf_err, output, 1, sticky Overflow-consistency error.
REQ-013 SHALL have port Err_sticky, output, 1, high while the FSM is in FAULT.
REQ-014 SHALL have port Wrap_cnt, output, WRAP_W, count of observed 7->0 wraps.

Function
REQ-015 SHALL decode Gray to binary as b2=g2, b1=g2^g1, b0=b1^g0.
REQ-016 SHALL register the decode into Bin and assert Bin_valid exactly one cycle after a Valid cycle (latency 1).
REQ-017 SHALL deassert Bin_valid and hold Bin in any cycle following a cycle without Valid.
REQ-018 SHALL implement FSM states IDLE, TRACK and FAULT, with reset state IDLE.
REQ-019 SHALL, in IDLE on Valid, store the decode as prev, perform no step check, and go to TRACK.
REQ-020 SHALL, in TRACK on Valid, compute d = (bin - prev) mod 8 and update prev to bin.
REQ-021 SHALL treat d=0 as a stall: no error and no state change.
REQ-022 SHALL treat d=1 as a legal step.
REQ-023 SHALL treat d in 2..7 as illegal: pulse Step_err on the next cycle and go to FAULT.
REQ-024 SHALL, on a legal step with prev=7 and bin=0, increment Wrap_cnt, saturating at 2^WRAP_W-1.
REQ-025 SHALL set Ovf_err if a legal 7->0 step is sampled with Ovf_in=0.
REQ-026 SHALL set Ovf_err if Ovf_in is sampled 1 while Wrap_cnt=0 and no wrap occurs in that sample.
REQ-027 SHALL set Ovf_err if Ovf_in is sampled 0 after having been sampled 1 since the last clear.
REQ-028 SHALL keep Ovf_err set until reset or Clr.
REQ-029 SHALL, in FAULT, continue decoding and updating Bin/Bin_valid but freeze Wrap_cnt, perform no step or Ovf checks, and pulse no further Step_err.
REQ-030 SHALL leave FAULT only on reset or Clr.
REQ-031 SHALL make Clr, regardless of state, return the FSM to IDLE and clear Wrap_cnt, Ovf_err, Err_sticky, Step_err, Bin_valid and prev; Bin holds.
REQ-032 SHALL let Clr win when Clr and Valid occur in the same cycle, discarding the sample.
REQ-033 SHALL perform no checks on cycles without Valid; samples need not be on consecutive cycles.

Reset
REQ-034 SHALL, with Reset=0 at a rising edge, set Bin=0, Bin_valid=0, Step_err=0, Ovf_err=0, Err_sticky=0, Wrap_cnt=0, prev=0 and state IDLE.
REQ-035 SHALL give Reset priority over Clr and Valid, including mid-sequence and in FAULT.

Structure
REQ-036 SHALL place the FSM state enum, the GRAY_W constant and the gray-to-binary function in shared package gray_pkg.
REQ-037 SHALL implement the decode as combinational sub-module gray2bin, instantiated once.

Verification
REQ-038 SHALL cover a full cycle: Valid on every cycle with Gray 000,001,011,010,110,111,101,100,000 and Ovf_in rising with the 000 -> Bin 0..7,0 with Bin_valid each cycle, Wrap_cnt=1, no errors.
REQ-039 SHALL cover a stall: Gray 011 sampled three times then 010 -> no Step_err, Bin=2,2,2,3.
REQ-040 SHALL cover an illegal jump: after 001 (bin 1) apply 110 (bin 4) -> Step_err pulse one cycle later, Err_sticky=1, Wrap_cnt frozen.
REQ-041 SHALL cover a missing overflow: a 100->000 step with Ovf_in=0 -> Ovf_err=1 and Wrap_cnt=1.
REQ-042 SHALL cover Clr with Valid in FAULT -> state IDLE, all flags 0, Wrap_cnt=0, sample discarded, Bin unchanged.
REQ-043 SHALL cover a reset mid-sequence: Reset=0 at Bin=5 with Wrap_cnt=3 -> all outputs 0 next cycle, next Valid accepted with no step check.
